// File: rtl/finn_rtl_krnl_example_pkg.sv
// Shared types and helpers for the FINN RTL example number checker.
package finn_rtl_krnl_example_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == ALL_ONES) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/finn_rtl_krnl_example_lane_compare.sv
// Combinational lane check: flags a beat whose lanes differ from base+lane+constant.
module finn_rtl_krnl_example_lane_compare
    import finn_rtl_krnl_example_pkg::*;
#(
    parameter int DATA_W = 512,
    parameter int NUM_W  = 32
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [NUM_W-1:0]  i_base,
    input  logic [NUM_W-1:0]  i_const,
    output logic              o_mismatch
);

    localparam int LANES = DATA_W / NUM_W;

    // OR-reduce per-lane inequality against the running expected sequence
    always_comb begin
        logic [NUM_W-1:0] w_exp;
        o_mismatch = 1'b0;
        w_exp      = '0;
        for (int i = 0; i < LANES; i++) begin
            w_exp = i_base + NUM_W'(i) + i_const;
            if (i_data[i*NUM_W +: NUM_W] != w_exp) begin
                o_mismatch = 1'b1;
            end else begin
                o_mismatch = o_mismatch;
            end
        end
    end

endmodule

// File: rtl/finn_rtl_krnl_example_number_checker.sv
// Stream checker for an incrementing number sequence offset by a constant.
// Optional first-error capture enabled by defining NUMBER_CHECKER_FIRST_ERR_EN.
module finn_rtl_krnl_example_number_checker
    import finn_rtl_krnl_example_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 512,
    parameter int C_NUMBER_BIT_WIDTH   = 32,
    parameter int C_LENGTH_IN_BYTES    = 16384
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic                              ap_start,
    input  logic [C_NUMBER_BIT_WIDTH-1:0]     ctrl_constant,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                              s_axis_tlast,
    output logic                              ap_done,
    output logic [31:0]                       error_count,
    output logic [31:0]                       first_err_beat
);

    localparam int LANES  = C_S_AXIS_TDATA_WIDTH / C_NUMBER_BIT_WIDTH;
    localparam int KEEP_W = C_S_AXIS_TDATA_WIDTH / 8;
    localparam int BEATS  = C_LENGTH_IN_BYTES / KEEP_W;

    state_e                        r_state;
    logic                          r_tready;
    logic                          r_done;
    logic [31:0]                   r_err_cnt;
    logic [31:0]                   r_beat_cnt;
    logic [C_NUMBER_BIT_WIDTH-1:0] r_base;
    logic [C_NUMBER_BIT_WIDTH-1:0] r_const;

    logic w_accept;
    logic w_last_beat;
    logic w_lane_mis;
    logic w_beat_mis;

    assign w_accept    = s_axis_tvalid & r_tready;
    assign w_last_beat = (r_beat_cnt == 32'(BEATS - 1));
    assign w_beat_mis  = w_lane_mis
                       | (s_axis_tkeep != {KEEP_W{1'b1}})
                       | (s_axis_tlast != w_last_beat);

    finn_rtl_krnl_example_lane_compare #(
        .DATA_W (C_S_AXIS_TDATA_WIDTH),
        .NUM_W  (C_NUMBER_BIT_WIDTH)
    ) u_lane_compare (
        .i_data     (s_axis_tdata),
        .i_base     (r_base),
        .i_const    (r_const),
        .o_mismatch (w_lane_mis)
    );

    // Control FSM with registered tready/done and per-run counters
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= IDLE;
            r_tready   <= 1'b0;
            r_done     <= 1'b0;
            r_err_cnt  <= 32'd0;
            r_beat_cnt <= 32'd0;
            r_base     <= '0;
            r_const    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (ap_start) begin
                        r_state    <= RUN;
                        r_tready   <= 1'b1;
                        r_err_cnt  <= 32'd0;
                        r_beat_cnt <= 32'd0;
                        r_base     <= '0;
                        r_const    <= ctrl_constant;
                    end else begin
                        r_state  <= IDLE;
                        r_tready <= 1'b0;
                    end
                end
                RUN: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        if (w_beat_mis) begin
                            r_err_cnt <= sat_inc32(r_err_cnt);
                        end
                        r_beat_cnt <= r_beat_cnt + 32'd1;
                        // Expected base advances additively; no multiplier.
                        r_base     <= r_base + C_NUMBER_BIT_WIDTH'(LANES);
                        if (w_last_beat) begin
                            r_state  <= DONE;
                            r_tready <= 1'b0;
                            r_done   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state  <= IDLE;
                    r_tready <= 1'b0;
                    r_done   <= 1'b0;
                end
                default: begin
                    r_state  <= IDLE;
                    r_tready <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

`ifdef NUMBER_CHECKER_FIRST_ERR_EN
    logic [31:0] r_first_err;

    // Capture beat index of the first mismatch; a zero error count marks "none yet"
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_first_err <= ALL_ONES;
        end else if ((r_state == IDLE) && ap_start) begin
            r_first_err <= ALL_ONES;
        end else if ((r_state == RUN) && w_accept && w_beat_mis && (r_err_cnt == 32'd0)) begin
            r_first_err <= r_beat_cnt;
        end
    end

    assign first_err_beat = r_first_err;
`else
    assign first_err_beat = ALL_ONES;
`endif

    assign s_axis_tready = r_tready;
    assign ap_done       = r_done;
    assign error_count   = r_err_cnt;

endmodule
